match_pe_scheduler: RTL

MATCH_PE_SCHEDULER -- requirements
Module: match_pe_scheduler

---
 rtl/match_pe_scheduler.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/match_pe_scheduler.sv
// match_pe_scheduler
//
// Scoreboard-driven scheduler for a fixed-latency match PE pipeline.
// A request claims a scoreboard slot, issues one beat into the PE pipeline,
// and collects the per-beat match length. With the extension enabled, a beat
// that matched its full width (and was not the final permissible beat)
// re-issues the slot at addresses advanced by one PE width. Otherwise the
// beat ends the slot and a saturated total length is reported.
//
// Configuration macro: MATCH_SCHED_EXT_EN
//   defined   : full-width beats re-issue the slot and accumulate
//   undefined : every beat is final, o_pe_last is tied high
//
// Shared widths normally come from parameters.vh; fallbacks are provided
// here so the block elaborates on its own.

`ifndef MATCH_PE_WIDTH
`define MATCH_PE_WIDTH 16
`endif
`ifndef MAX_MATCH_LEN
`define MAX_MATCH_LEN 64
`endif
`ifndef MATCH_LEN_WIDTH
`define MATCH_LEN_WIDTH 7
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module match_pe_scheduler #(
    parameter int SCOREBOARD_ENTRY_INDEX = 2,
    parameter int PIPE_LAT               = 6
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              i_req_valid,
    output logic                              o_req_ready,
    input  logic [SCOREBOARD_ENTRY_INDEX-1:0] i_req_idx,
    input  logic [`ADDR_WIDTH-1:0]            i_req_head_addr,
    input  logic [`ADDR_WIDTH-1:0]            i_req_history_addr,

    output logic                              o_pe_valid,
    output logic                              o_pe_last,
    output logic [SCOREBOARD_ENTRY_INDEX-1:0] o_pe_idx,
    output logic [`ADDR_WIDTH-1:0]            o_pe_head_addr,
    output logic [`ADDR_WIDTH-1:0]            o_pe_history_addr,

    input  logic                              i_pe_valid,
    input  logic                              i_pe_last,
    input  logic [SCOREBOARD_ENTRY_INDEX-1:0] i_pe_idx,
    input  logic [`MATCH_LEN_WIDTH-1:0]       i_pe_match_len,

    output logic                              o_res_valid,
    output logic [SCOREBOARD_ENTRY_INDEX-1:0] o_res_idx,
    output logic [`MATCH_LEN_WIDTH-1:0]       o_res_match_len,

    output logic                              o_busy,
    output logic                              o_err
);

    localparam int IDX_W  = SCOREBOARD_ENTRY_INDEX;
    localparam int N_SLOT = 1 << IDX_W;
    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int LEN_W  = `MATCH_LEN_WIDTH;

    // Lengths are compared one bit wider so accum + PE width never wraps.
    localparam logic [LEN_W:0]    PE_W_EXT  = (LEN_W+1)'(`MATCH_PE_WIDTH);
    localparam logic [LEN_W:0]    MAX_LEN   = (LEN_W+1)'(`MAX_MATCH_LEN);
    localparam logic [LEN_W-1:0]  PE_W_LEN  = LEN_W'(`MATCH_PE_WIDTH);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(`MATCH_PE_WIDTH);

    // The scheduler does not need the pipeline latency: results are matched
    // to slots by the echoed index, so any latency works.
    logic [31:0] unused_pipe_lat;
    assign unused_pipe_lat = 32'(PIPE_LAT);

    // ------------------------------------------------------------------
    // Length helpers
    // ------------------------------------------------------------------

    // Sum of two lengths clamped to the maximum match length.
    function automatic logic [LEN_W-1:0] sat_len_add(
        input logic [LEN_W-1:0] a,
        input logic [LEN_W-1:0] b
    );
        logic [LEN_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > MAX_LEN) begin
            return MAX_LEN[LEN_W-1:0];
        end
        return sum[LEN_W-1:0];
    endfunction

`ifdef MATCH_SCHED_EXT_EN
    // A beat is the last permissible one when a full-width match on it
    // would reach the maximum match length.
    function automatic logic beat_is_last(input logic [LEN_W-1:0] accum);
        logic [LEN_W:0] reach;
        reach = {1'b0, accum} + PE_W_EXT;
        return (reach >= MAX_LEN);
    endfunction
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    // Per-slot scoreboard. busy is control; the rest is data.
    logic [N_SLOT-1:0] busy_q;
    logic [N_SLOT-1:0] busy_d;
    logic [LEN_W-1:0]  accum_q   [N_SLOT];
    logic [ADDR_W-1:0] head_q    [N_SLOT];
    logic [ADDR_W-1:0] hist_q    [N_SLOT];

    // Issue port registers.
    logic              pe_valid_q;
    logic [IDX_W-1:0]  pe_idx_q;
    logic [ADDR_W-1:0] pe_head_q;
    logic [ADDR_W-1:0] pe_hist_q;

    // Result port registers.
    logic              res_valid_q;
    logic [IDX_W-1:0]  res_idx_q;
    logic [LEN_W-1:0]  res_len_q;

    logic              err_q;

    // ------------------------------------------------------------------
    // Decode of the current cycle
    // ------------------------------------------------------------------

    logic              pe_hit;
    logic              pe_stale;
    logic              reissue_pending;
    logic              slot_done;
    logic              req_ready;
    logic              accept;
    logic [LEN_W-1:0]  accum_cur;
    logic [LEN_W-1:0]  accum_adv;
    logic [ADDR_W-1:0] head_adv;
    logic [ADDR_W-1:0] hist_adv;

    // Classify the incoming PE result and the incoming request.
    always_comb begin
        pe_hit   = i_pe_valid && busy_q[i_pe_idx];
        pe_stale = i_pe_valid && !busy_q[i_pe_idx];

`ifdef MATCH_SCHED_EXT_EN
        // A full-width match that was not the final beat continues the slot.
        reissue_pending = pe_hit && (i_pe_match_len == PE_W_LEN) && !i_pe_last;
`else
        reissue_pending = 1'b0;
`endif

        slot_done = pe_hit && !reissue_pending;

        // A re-issue owns the issue port next cycle, so new requests wait.
        req_ready = !rst && !busy_q[i_req_idx] && !reissue_pending;
        accept    = i_req_valid && req_ready;

        accum_cur = accum_q[i_pe_idx];
        accum_adv = sat_len_add(accum_cur, PE_W_LEN);
        head_adv  = head_q[i_pe_idx] + ADDR_STEP;
        hist_adv  = hist_q[i_pe_idx] + ADDR_STEP;
    end

`ifndef MATCH_SCHED_EXT_EN
    // Without the extension every beat is final, so the echoed last flag
    // carries no information.
    logic unused_pe_last;
    assign unused_pe_last = i_pe_last;
`endif

    // Busy bits: a slot is claimed on accept and released one cycle after
    // its result pulse, so it only becomes reusable after the pulse.
    always_comb begin
        busy_d = busy_q;
        if (res_valid_q) begin
            busy_d[res_idx_q] = 1'b0;
        end
        if (accept) begin
            busy_d[i_req_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control registers (reset)
    // ------------------------------------------------------------------

    // Slot ownership, port valids and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            pe_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            pe_valid_q  <= accept || reissue_pending;
            res_valid_q <= slot_done;
            if (pe_stale) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data registers (no reset)
    // ------------------------------------------------------------------

    // Scoreboard contents and issue payload: a new request starts the slot
    // at its given addresses, a re-issue advances it by one PE width.
    always_ff @(posedge clk) begin
        if (accept) begin
            accum_q[i_req_idx] <= '0;
            head_q[i_req_idx]  <= i_req_head_addr;
            hist_q[i_req_idx]  <= i_req_history_addr;
            pe_idx_q           <= i_req_idx;
            pe_head_q          <= i_req_head_addr;
            pe_hist_q          <= i_req_history_addr;
        end else if (reissue_pending) begin
            accum_q[i_pe_idx]  <= accum_adv;
            head_q[i_pe_idx]   <= head_adv;
            hist_q[i_pe_idx]   <= hist_adv;
            pe_idx_q           <= i_pe_idx;
            pe_head_q          <= head_adv;
            pe_hist_q          <= hist_adv;
        end
    end

`ifdef MATCH_SCHED_EXT_EN
    logic pe_last_q;

    // Last-beat flag follows the accumulated length of the beat being issued.
    always_ff @(posedge clk) begin
        if (accept) begin
            pe_last_q <= beat_is_last('0);
        end else if (reissue_pending) begin
            pe_last_q <= beat_is_last(accum_adv);
        end
    end

    assign o_pe_last = pe_last_q;
`else
    assign o_pe_last = 1'b1;
`endif

    // Final result payload: accumulated length plus this beat, saturated.
    always_ff @(posedge clk) begin
        if (slot_done) begin
            res_idx_q <= i_pe_idx;
            res_len_q <= sat_len_add(accum_cur, i_pe_match_len);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    assign o_req_ready       = req_ready;
    assign o_pe_valid        = pe_valid_q;
    assign o_pe_idx          = pe_idx_q;
    assign o_pe_head_addr    = pe_head_q;
    assign o_pe_history_addr = pe_hist_q;
    assign o_res_valid       = res_valid_q;
    assign o_res_idx         = res_idx_q;
    assign o_res_match_len   = res_len_q;
    assign o_busy            = !rst && (|busy_q);
    assign o_err             = err_q;

endmodule
